fetch_unit: RTL

Front end of the 5-stage pipeline: owns the PC and the IF/ID pipeline register, and issues instruction-memory reads. It consumes the hazard controls `fe_enable` / `ifid_clear` and the EX-stage `redirect_valid` / `redirect_pc`. It buffers one in-flight fetch so that a stall never loses or duplicates an instruction.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Pipeline front end: PC, IF/ID register and a one-deep fetch buffer so that
// stalls neither drop nor repeat instructions; chains requests for 1 instr/cycle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fe_enable,
  input  logic               ifid_clear,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               ifid_valid,
  output logic [31:0]        ifid_pc,
  output logic [31:0]        ifid_instr
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] buf_q, buf_d;
  logic [2:0]  stale_q, stale_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        take, rsp_live, bubble, load;
  logic        req_d;
  logic [31:0] addr_d, pc_inc, load_word;

  always_comb begin
    take      = fe_enable & ~ifid_clear & ~redirect_valid;
    pc_inc    = fetch_pc_q + 32'd4;
    rsp_live  = imem.rvalid && (stale_q == 3'd0);

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    buf_d        = buf_q;
    stale_d      = stale_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    req_d        = 1'b0;
    addr_d       = fetch_pc_q;
    bubble       = 1'b0;
    load         = 1'b0;
    load_word    = buf_q;

    // Responses are in order, so any rvalid while stale responses are owed is one of them.
    if (imem.rvalid && (stale_q != 3'd0))
      stale_d = stale_q - 3'd1;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      bubble     = 1'b1;
      state_d    = S_IDLE;
      if ((state_q == S_WAIT) && !rsp_live)
        stale_d = stale_d + 3'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_d = 1'b1;
          if (imem.gnt) state_d = S_WAIT;
          // Advancing with nothing fetched must not replay the old IF/ID entry.
          bubble = fe_enable | ifid_clear;
        end
        S_WAIT: begin
          if (rsp_live) begin
            if (take) begin
              load      = 1'b1;
              load_word = imem.rdata;
            end else begin
              buf_d   = imem.rdata;
              state_d = S_HOLD;
              bubble  = ifid_clear;
            end
          end else begin
            bubble = fe_enable | ifid_clear;
          end
        end
        S_HOLD: begin
          if (take) load = 1'b1;
          else      bubble = ifid_clear;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (bubble) begin
      ifid_valid_d = 1'b0;
      ifid_pc_d    = 32'h0;
      ifid_instr_d = NOP_INSTR;
    end

    // Consuming an instruction chains the next request in the same cycle.
    if (load) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = fetch_pc_q;
      ifid_instr_d = load_word;
      fetch_pc_d   = pc_inc;
      req_d        = 1'b1;
      addr_d       = pc_inc;
      state_d      = imem.gnt ? S_WAIT : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      buf_q        <= NOP_INSTR;
      stale_q      <= 3'd0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      buf_q        <= buf_d;
      stale_q      <= stale_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem.req   = req_d & rst_n;
  assign imem.addr  = addr_d;
  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_instr = ifid_instr_q;

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    imem.req && !imem.gnt |=> !imem.req || $stable(imem.addr));
  a_hold_no_req: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_HOLD) && !take |-> !imem.req);

endmodule
